// File: rtl/lfsr_pkg.sv
// Shared types and constants for the 8-bit XNOR LFSR and its request scheduler.
// Step function lives here so the core and any consumer agree on the sequence.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    WARMUP = 2'd2,
    SERVE  = 2'd3
  } lfsr_sched_state_t;

  localparam int               LFSR_W         = 8;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP    = 8'hFF;
  localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 8'h00;
  localparam int               TAP_A          = 2;
  localparam int               TAP_B          = 5;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ~(cur[TAP_A] ^ cur[TAP_B])};
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// LFSR state register: load (with lock-up seed substitution) beats step; otherwise holds.
// One-cycle update, no flow control.
module lfsr_step_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      // All-ones is the XNOR lock-up state; never let it in.
      q_d = (seed == LFSR_LOCKUP) ? LFSR_SAFE_SEED : seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_sched.sv
// Seeds the shared LFSR, runs the warm-up, then grants one fresh byte per cycle round-robin.
// Grant/rnd appear one cycle after req is sampled; the LFSR steps once per grant.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WARMUP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [LFSR_W-1:0]   seed,
  input  logic [WARMUP_W-1:0] warmup,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic [LFSR_W-1:0]   rnd,
  output logic                rnd_valid,
  output logic                busy,
  output logic                serving
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  lfsr_sched_state_t   state_q;
  logic [WARMUP_W-1:0] cnt_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [NREQ-1:0]     gnt_q;
  logic [LFSR_W-1:0]   rnd_q;
  logic                rnd_valid_q;

  logic [LFSR_W-1:0]   lfsr_q;
  logic                lfsr_load;
  logic                lfsr_step;

  logic                found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    ptr_d;

  // First set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    int j;
    found   = 1'b0;
    win_idx = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
    ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // A stop edge leaves q untouched, so neither load nor step fires under stop.
  assign lfsr_load = (state_q == SEED) && !stop;
  assign lfsr_step = !stop && ((state_q == WARMUP) || ((state_q == SERVE) && found));

  lfsr_step_core u_core (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      if (state_q != IDLE && stop) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !stop) state_q <= SEED;
          end
          SEED: begin
            cnt_q   <= warmup;
            state_q <= (warmup != '0) ? WARMUP : SERVE;
          end
          WARMUP: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == WARMUP_W'(1)) state_q <= SERVE;
          end
          SERVE: begin
            if (found) begin
              gnt_q       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
              rnd_q       <= lfsr_q;
              rnd_valid_q <= 1'b1;
              ptr_q       <= ptr_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = (state_q == SEED) || (state_q == WARMUP);
  assign serving   = (state_q == SERVE);

endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Scheduler for a shared 8-bit pseudo-random source. It seeds the LFSR, runs a programmable warm-up, then hands one fresh random byte per cycle to up to NREQ requesters. Access is round-robin, and the LFSR steps once per grant so that no two grants ever receive the same state. It sits between the shared XNOR-feedback LFSR datapath and the blocks that consume random values (test-pattern, scrambler and backoff logic).

## Interface
- NREQ, 4: number of requesters (2..8)
- WARMUP_W, 8: width of the warm-up cycle count
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; all registers go to reset values immediately
- start  in  1  pulse; begins a seed/warm-up/serve run (sampled only in IDLE)
- stop  in  1  pulse; aborts any run and returns to IDLE
- seed  in  8  LFSR seed, captured in SEED state
- warmup  in  WARMUP_W  number of LFSR steps before serving, captured in SEED state
- req  in  NREQ  per-requester level request
- gnt  out  NREQ  one-hot registered grant, single cycle
- rnd  out  8  random byte for the granted requester, valid with gnt
- rnd_valid  out  1  high exactly when gnt is non-zero
- busy  out  1  high in SEED and WARMUP
- serving  out  1  high in SERVE

## Operation
- LFSR: 8-bit register q. fb = ~(q[2] ^ q[5]). Step: q <= {q[6:0], fb}.
- Lock-up state is 8'hFF. A seed of 8'hFF is replaced by 8'h00 at load.
- States: IDLE, SEED, WARMUP, SERVE (2-bit encoding, IDLE = 0).
- IDLE: LFSR holds. start=1 and stop=0 moves to SEED.
- SEED (one cycle): q <= seed (FF substitution applied); warm-up counter <= warmup. Next state is WARMUP if warmup != 0, else SERVE.
- WARMUP: q steps every cycle and the counter decrements. Leaves for SERVE on the cycle the counter goes 1 -> 0, so exactly warmup steps are taken.
- SERVE arbitration:
  - If any req bit is high, pick the first set bit searching from pointer ptr upward, modulo NREQ.
  - Next cycle: gnt = onehot(i), rnd = q (pre-step value), rnd_valid = 1.
  - On the same edge, q steps and ptr <= (i+1) mod NREQ.
  - No request: gnt = 0, rnd_valid = 0, q and ptr hold.
- stop=1 in any non-IDLE state: go to IDLE at the next edge. gnt and rnd_valid are 0 from that edge, even if a req was pending. q keeps its current value.
- start in a non-IDLE state is ignored. start and stop high together in IDLE: stay in IDLE.
- rnd holds its last value when rnd_valid=0.

## Timing
- Reset values: state IDLE, q 8'h00, ptr 0, counter 0, gnt 0, rnd 8'h00, rnd_valid 0, busy 0, serving 0.
- start sampled at edge T0: SEED during cycle T0+1, then WARMUP or SERVE from T0+2.
- First grant possible at edge T0+2+warmup, with req sampled in the first SERVE cycle. Outputs appear one cycle later.
- Grant latency: req sampled at edge t gives gnt/rnd valid in cycle t+1 for one cycle.
- Throughput: one grant per cycle. A requester holding req alone is granted every cycle. With all bits held, grants rotate 0,1,2,3,0,…
- busy and serving are decoded from the registered state; there is no combinational path from req to any output.
- reset asserted mid-run takes effect asynchronously. After release the block waits in IDLE for a new start.

## Structure
- Shared package lfsr_pkg holds:
  - state enum lfsr_sched_state_t (IDLE, SEED, WARMUP, SERVE)
  - LFSR_W = 8
  - LFSR_LOCKUP = 8'hFF
  - LFSR_SAFE_SEED = 8'h00
  - tap indices TAP_A = 2, TAP_B = 5
- Sub-module lfsr_step_core: q register with load/seed/step inputs, XNOR feedback and lock-up substitution. lfsr_sched instantiates it and owns the FSM, counter and round-robin arbiter.

## Test plan
- Reset, then start with seed=8'h01, warmup=0, req=4'b0001 held: grants to req0 on consecutive cycles with rnd = 01, 03, 07, 0E.
- seed=8'h01, warmup=3, req=4'b0001: busy high for 4 cycles (SEED + 3 WARMUP), then first rnd = 8'h0E.
- SERVE with req=4'b1111 held for 5 grants: gnt = 0001, 0010, 0100, 1000, 0001; all rnd values distinct and following the step sequence.
- seed=8'hFF, warmup=0: first rnd = 8'h00, second = 8'h01 (no lock-up).
- stop asserted in SERVE with req=4'b0010 pending: gnt=0 and rnd_valid=0 from the next cycle; state IDLE; later start values are ignored until IDLE.
- reset pulsed mid-WARMUP: outputs immediately take reset values; state IDLE and q = 8'h00 after release.
